// File: rtl/keccak_pkg.sv
// Shared Keccak constants, padder state type and width helper.
// The pad byte is selected by the optional KECCAK_PAD_SHA3_EN macro.
package keccak_pkg;

    localparam int KECCAK512_RATE = 576;

`ifdef KECCAK_PAD_SHA3_EN
    localparam logic [7:0] KECCAK_PAD_BYTE = 8'h06;
`else
    localparam logic [7:0] KECCAK_PAD_BYTE = 8'h01;
`endif

    localparam logic [7:0] KECCAK_PAD_LAST = 8'h80;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } pad_state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/keccak_pad_word.sv
// Pads a final message word: keeps the first byte_num bytes, inserts the pad byte,
// zeroes the rest. Byte 0 sits in the MSBs.
module keccak_pad_word
    import keccak_pkg::*;
#(
    parameter  int IW  = 64,
    localparam int NB  = IW / 8,
    localparam int BNW = clog2_min1(NB)
) (
    input  logic [IW-1:0]  in,
    input  logic [BNW-1:0] byte_num,
    output logic [IW-1:0]  out
);

    for (genvar b = 0; b < NB; b++) begin : g_byte
        localparam logic [BNW-1:0] B = BNW'(b);

        // Per-byte select among message data, pad byte and zero.
        always_comb begin
            if (B < byte_num) begin
                out[IW-1-8*b -: 8] = in[IW-1-8*b -: 8];
            end else if (B == byte_num) begin
                out[IW-1-8*b -: 8] = KECCAK_PAD_BYTE;
            end else begin
                out[IW-1-8*b -: 8] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/keccak_block_padder.sv
// Accumulates IW-bit message words into RATE-bit Keccak blocks with pad10*1 padding
// on the final block. Pad byte 0x06 instead of 0x01 when KECCAK_PAD_SHA3_EN is defined.
module keccak_block_padder
    import keccak_pkg::*;
#(
    parameter  int IW   = 64,
    parameter  int RATE = KECCAK512_RATE,
    localparam int NB   = IW / 8,
    localparam int BNW  = clog2_min1(NB)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [IW-1:0]   in,
    input  logic            in_valid,
    input  logic            in_last,
    input  logic [BNW-1:0]  byte_num,
    output logic            in_ready,
    output logic [RATE-1:0] out,
    output logic            out_valid,
    output logic            out_last,
    input  logic            out_ready
);

    localparam int              W       = RATE / IW;
    localparam int              IDXW    = clog2_min1(W);
    localparam logic [IDXW-1:0] IDX_MAX = IDXW'(W - 1);

    pad_state_e      state_r, state_s;
    logic [IDXW-1:0] idx_r, idx_s;
    logic [RATE-1:0] block_r, block_s;
    logic            valid_r, valid_s;
    logic            last_r, last_s;
    logic [IW-1:0]   pad_word_s;
    logic            accept_s;

    keccak_pad_word #(.IW(IW)) u_pad_word (
        .in       (in),
        .byte_num (byte_num),
        .out      (pad_word_s)
    );

    // State, block register and handshake flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= FILL;
            idx_r   <= '0;
            block_r <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            block_r <= block_s;
            valid_r <= valid_s;
            last_r  <= last_s;
        end
    end

    // Next-state: word write in FILL, block hand-off and clear in FULL.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        block_s  = block_r;
        valid_s  = valid_r;
        last_s   = last_r;
        accept_s = in_valid && (state_r == FILL);
        case (state_r)
            FILL: begin
                if (accept_s) begin
                    block_s[RATE-1-int'(idx_r)*IW -: IW] = in_last ? pad_word_s : in;
                    if (in_last) begin
                        block_s[7:0] = block_s[7:0] | KECCAK_PAD_LAST;
                    end else begin
                        block_s[7:0] = block_s[7:0];
                    end
                    if (in_last || (idx_r == IDX_MAX)) begin
                        state_s = FULL;
                        valid_s = 1'b1;
                        last_s  = in_last;
                    end else begin
                        idx_s = idx_r + IDXW'(1);
                    end
                end else begin
                    state_s = FILL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_s = FILL;
                    idx_s   = '0;
                    block_s = '0;
                    valid_s = 1'b0;
                    last_s  = 1'b0;
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s = FILL;
                idx_s   = '0;
                block_s = '0;
                valid_s = 1'b0;
                last_s  = 1'b0;
            end
        endcase
    end

    assign in_ready  = (state_r == FILL);
    assign out       = block_r;
    assign out_valid = valid_r;
    assign out_last  = last_r;

endmodule

// File: tb/tb_keccak_block_padder.sv
// Randomized bench for keccak_block_padder against a byte-level pad10*1 model.
module tb_keccak_block_padder;

    localparam int IW   = 64;
    localparam int RATE = 576;
    localparam int BPB  = RATE / 8;

`ifdef KECCAK_PAD_SHA3_EN
    localparam logic [7:0] PAD = 8'h06;
`else
    localparam logic [7:0] PAD = 8'h01;
`endif

    typedef logic [7:0] bq_t[$];

    logic            clk = 1'b0;
    logic            reset_n;
    logic [IW-1:0]   in_w;
    logic            in_valid;
    logic            in_last;
    logic [2:0]      byte_num;
    logic            in_ready;
    logic [RATE-1:0] out_blk;
    logic            out_valid;
    logic            out_last;
    logic            out_ready = 1'b0;

    logic            mon_rand = 1'b0;
    logic            ready_force = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [RATE-1:0] exp_blk_q[$];
    logic            exp_last_q[$];

    keccak_block_padder #(.IW(IW), .RATE(RATE)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in        (in_w),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .byte_num  (byte_num),
        .in_ready  (in_ready),
        .out       (out_blk),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [RATE-1:0] obs, input logic [RATE-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Message bytes -> padded byte stream -> expected blocks.
    task automatic model_push(input bq_t m);
        bq_t             pb;
        int              nblk;
        logic [RATE-1:0] blk;
        nblk = m.size() / BPB + 1;
        pb = m;
        pb.push_back(PAD);
        while (pb.size() < nblk * BPB) pb.push_back(8'h00);
        pb[nblk*BPB-1] = pb[nblk*BPB-1] | 8'h80;
        for (int b = 0; b < nblk; b++) begin
            blk = '0;
            for (int i = 0; i < BPB; i++) blk[RATE-1-8*i -: 8] = pb[b*BPB+i];
            exp_blk_q.push_back(blk);
            exp_last_q.push_back(b == nblk - 1);
        end
    endtask

    function automatic bq_t rand_msg(input int len);
        bq_t q;
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic send_msg(input bq_t m, input bit gaps);
        int   len;
        int   nfull;
        bit   accepted;
        model_push(m);
        len   = m.size();
        nfull = len / 8;
        for (int w = 0; w <= nfull; w++) begin
            logic [IW-1:0] word;
            bit            last;
            int            nb;
            last = (w == nfull);
            nb   = last ? len % 8 : 8;
            for (int k = 0; k < 8; k++)
                word[IW-1-8*k -: 8] = (k < nb) ? m[8*w+k] : 8'($urandom);
            accepted = 1'b0;
            for (int t = 0; t < 1000 && !accepted; t++) begin
                @(negedge clk);
                in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_w     = word;
                in_last  = last;
                byte_num = last ? 3'(nb) : 3'($urandom);
                accepted = in_valid && in_ready;
            end
            if (!accepted) check_eq("accept_timeout", 1'b0, 1'b1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 5000 && exp_blk_q.size() != 0; t++) @(posedge clk);
        check_eq("drain", RATE'(exp_blk_q.size()), '0);
    endtask

    // Sink: drives out_ready and scores every block handed off.
    always @(negedge clk) begin
        out_ready = mon_rand ? ($urandom_range(0, 2) != 0) : ready_force;
        if (reset_n && out_valid && out_ready) begin
            if (exp_blk_q.size() == 0) begin
                check_eq("extra_block", 1'b1, 1'b0);
            end else begin
                check_eq("block", out_blk, exp_blk_q.pop_front());
                check_eq("out_last", out_last, exp_last_q.pop_front());
            end
        end
    end

    initial begin
        bq_t           m;
        logic [IW-1:0] held;
        logic [RATE-1:0] saved;

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_w     = '0;
        byte_num = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_last", out_last, 1'b0);
        check_eq("rst_out", out_blk, '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1'b1);

        // Empty message, held in FULL.
        m = {};
        send_msg(m, 1'b0);
        check_eq("empty_valid", out_valid, 1'b1);
        check_eq("empty_last", out_last, 1'b1);
        check_eq("empty_msb", out_blk[RATE-1 -: 8], PAD);
        check_eq("empty_lsb", out_blk[7:0], 8'h80);
        check_eq("empty_in_ready", in_ready, 1'b0);

        // Stall with source pressing a word.
        held = {$urandom, $urandom};
        @(negedge clk);
        in_valid = 1'b1;
        in_w     = held;
        in_last  = 1'b0;
        saved    = out_blk;
        repeat (5) begin
            @(posedge clk);
            #1;
            check_eq("stall_in_ready", in_ready, 1'b0);
            check_eq("stall_out", out_blk, saved);
            check_eq("stall_valid", out_valid, 1'b1);
        end
        ready_force = 1'b1;
        @(posedge clk);
        #1;
        check_eq("release_valid", out_valid, 1'b0);
        check_eq("release_in_ready", in_ready, 1'b1);
        m = rand_msg(BPB);
        for (int k = 0; k < 8; k++) m[k] = held[IW-1-8*k -: 8];
        send_msg(m, 1'b0);
        wait_drain();

        // Exactly one block of 0xA5.
        m = {};
        for (int i = 0; i < BPB; i++) m.push_back(8'hA5);
        send_msg(m, 1'b0);
        wait_drain();

        // 71 bytes: pad and final marker share the LSB byte.
        ready_force = 1'b0;
        m = rand_msg(64);
        for (int i = 1; i <= 7; i++) m.push_back(8'(8'h11 * i));
        send_msg(m, 1'b0);
        check_eq("b71_tail", out_blk[63:0], {56'h11223344556677, PAD | 8'h80});
        check_eq("b71_last", out_last, 1'b1);
        ready_force = 1'b1;
        wait_drain();

        // Reset after 4 accepted words discards the partial block.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_w     = {$urandom, $urandom} | 64'h1;
            in_last  = 1'b0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_valid", out_valid, 1'b0);
        check_eq("midrst_out", out_blk, '0);
        check_eq("midrst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        send_msg(rand_msg(BPB), 1'b0);
        wait_drain();

        // Random lengths, random gaps and back-pressure.
        mon_rand = 1'b1;
        for (int n = 0; n < 30; n++) send_msg(rand_msg($urandom_range(0, 160)), 1'b1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keccak_block_padder.md
# keccak_block_padder

Sequential, parametrised Keccak padder that accepts a message as a stream of IW-bit words and emits full RATE-bit blocks for the Keccak-f permutation, applying pad10*1 padding to the final word and final block. It sits between the integrity-unit message source and the Keccak-512 permutation core. It adds word accumulation, a valid/ready handshake on both sides, and automatic multi-block sequencing on top of the single-word combinational padding already in the Keccak datapath.

## Interface
- IW, 64: input word width in bits; any multiple of 8, 8 ≤ IW ≤ RATE.
- RATE, 576: block (rate) width in bits; a multiple of IW (576 for Keccak-512). W = RATE/IW words per block.
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in  in  IW  message word, byte 0 at in[IW-1:IW-8].
- in_valid  in  1  word present.
- in_last  in  1  this is the final word of the message.
- byte_num  in  clog2(IW/8)  valid bytes in a last word, 0..IW/8-1. Ignored when in_last=0.
- in_ready  out  1  padder accepts a word this cycle.
- out  out  RATE  assembled block, word 0 in the MSBs.
- out_valid  out  1  block ready for the permutation.
- out_last  out  1  block is the final block of the message. Qualified by out_valid.
- out_ready  in  1  permutation accepts the block.

## Operation
- States: FILL and FULL.
- FILL: in_ready=1. On in_valid&&in_ready, the word is written at index idx, the word counter.
  - Non-last word: stored unchanged; idx increments.
  - Last word: stored as the first byte_num bytes of in, then the pad byte, then zeros. The pad byte is 0x01.
  - Last word also ORs 0x80 into the block LSB byte out[7:0].
- FILL → FULL when a non-last word lands at idx=W-1, or on any last word. Entering FULL sets out_valid=1.
- out_last is set to in_last of the transition word.
- FULL: in_ready=0; out, out_valid and out_last are held stable.
- On out_valid&&out_ready: block register cleared to 0, idx←0, out_valid←0, out_last←0, state←FILL.
- A message whose data exactly fills a block still needs its own last word (byte_num=0). That last word yields a new block 0x01 00…00 80.
- Last word at idx=W-1 with byte_num=IW/8-1 gives LSB byte 0x81. No extra block is ever needed.
- Words at indices after the last word stay 0, because the register is cleared at every block start.
- The padder never emits a block without a last word or W accepted words.

## Timing
- Reset values: state=FILL, idx=0, out=0, out_valid=0, out_last=0; in_ready=1 after reset release.
- in_ready is combinational from state only. No combinational path exists from in_valid or out_ready to in_ready.
- Latency: out_valid rises 1 cycle after the accepting edge of the block-completing word.
- Throughput: one word per cycle in FILL. At least one bubble cycle per block: the FULL state lasts ≥1 cycle.
- in_valid during FULL: ignored, no state change. The source holds the word until in_ready.
- Asserting reset_n low mid-block or during FULL immediately clears all state. The partial block is discarded and out_valid drops asynchronously.
- idx width is clog2(W), with a minimum of 1. idx never exceeds W-1.

## Configuration
- KECCAK_PAD_SHA3_EN defined: the pad byte is 0x06, the FIPS-202 SHA-3 domain separation.
  - A last word at idx=W-1 with byte_num=IW/8-1 then gives LSB byte 0x86.
- KECCAK_PAD_SHA3_EN undefined: the pad byte is 0x01 (original Keccak). This is the default used by the integrity unit.

## Structure
- Shared package keccak_pkg:
  - KECCAK512_RATE=576.
  - Pad-byte constants KECCAK_PAD_BYTE (0x01/0x06, selected by the macro) and KECCAK_PAD_LAST=0x80.
  - State enum {FILL, FULL}.
- Sub-module keccak_pad_word: combinational, parametrised by IW. It takes (in, byte_num) and returns the padded word with the pad byte. It replaces per-width case lists with a generated byte mask.
- Top level holds the block register, idx counter, state register and handshake.

## Test plan
All scenarios use IW=64, RATE=576, W=9.
- Empty message: one last word, byte_num=0 → one block with out[575:568]=0x01, out[7:0]=0x80, all else 0, out_last=1, out_valid 1 cycle after accept.
- 9 full words of 0xA5, then last word byte_num=0 → block 1 all 0xA5 with out_last=0; block 2 = 0x01 00…00 80 with out_last=1.
- 8 full words, then last word byte_num=7 carrying 0x11…77 → single block whose LSB byte is 0x81, preceded by bytes 0x11…77; out_last=1.
- Completed block with out_ready held low 5 cycles while the source drives in_valid=1 → out stable and in_ready=0 throughout; no word consumed. After the out_ready pulse, the next word lands at idx=0.
- reset_n pulsed low after 4 words accepted → out_valid=0 and out=0. After release the next 9 words form a clean block starting at word 0.
- With KECCAK_PAD_SHA3_EN: empty message → out[575:568]=0x06, out[7:0]=0x80.
